fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 10'h000, byte address of first fetch after reset; bits [1:0] SHALL be 00.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: imem_pc  output  10  byte address presented to instruction memory; word-aligned.
REQ-005 Port: imem_instr  input  32  instruction word for the imem_pc presented one cycle earlier (registered-read memory).
REQ-006 Port: redirect_valid  input  1  branch/jump redirect request, single-cycle pulse.
REQ-007 Port: redirect_pc  input  10  redirect target; bits [1:0] ignored and treated as 00.
REQ-008 Port: id_valid  output  1  id_pc/id_instr hold a valid instruction for decode.
REQ-009 Port: id_ready  input  1  decode accepts; transfer occurs when id_valid && id_ready.
REQ-010 Port: id_pc  output  10  byte address of the instruction on id_instr.
REQ-011 Port: id_instr  output  32  fetched instruction word.

Function
REQ-012 State: fetch_pc (10b), in-flight flag plus in-flight pc (10b), 2-entry {pc, instr} FIFO with count 0..2.
REQ-013 pop = id_valid && id_ready; count_after_pop = count - pop.
REQ-014 issue is asserted when rst=0 and (count_after_pop + inflight) <= 1; otherwise there is no issue.
REQ-015 imem_pc is combinational: redirect_pc & ~3 when redirect_valid=1, else fetch_pc.
REQ-016 On issue: in-flight flag <= 1, in-flight pc <= imem_pc, fetch_pc <= imem_pc + 4; with no issue, the in-flight flag <= 0 and fetch_pc holds.
REQ-017 fetch_pc arithmetic is modulo 2^10: 10'h3FC + 4 wraps to 10'h000, with no error flag.
REQ-018 When the in-flight flag=1 and redirect_valid=0, {in-flight pc, imem_instr} is pushed into the FIFO tail that cycle.
REQ-019 id_valid = (count != 0) && !redirect_valid; id_pc/id_instr show the FIFO head, with no bypass from imem_instr.
REQ-020 Latency: an issue in cycle N shall make the instruction visible on id_* in cycle N+2 at the earliest.
REQ-021 Throughput: with id_ready held 1 and no redirect, one instruction per cycle in sequential pc order.
REQ-022 Simultaneous push and pop leaves count unchanged, and order SHALL be preserved.
REQ-023 FIFO never overflows by construction of REQ-014; a push when count=2 is a design error (assertion in bench).
REQ-024 Stall: with id_ready=0, id_valid/id_pc/id_instr SHALL hold stable until accepted.
REQ-025 Redirect cycle: flush the FIFO (count <= 0), drop any in-flight response arriving that cycle, and issue at redirect_pc, so fetch_pc <= redirect_pc + 4; no transfer occurs that cycle.
REQ-026 Redirect while id_ready=0 or FIFO full: flush takes priority, and the first post-redirect instruction appears 2 cycles later.
REQ-027 Back-to-back redirects: each one flushes, and only the last target's stream is delivered.

Reset
REQ-028 While rst=1: fetch_pc <= RESET_PC, in-flight flag <= 0, count <= 0, FIFO contents and id_pc/id_instr <= 0, and no issue occurs.
REQ-029 During rst=1: id_valid=0, imem_pc=RESET_PC (or redirect_pc if redirect_valid), id_pc=0, id_instr=0.
REQ-030 Reset asserted mid-stream discards all buffered and in-flight instructions, with no id_valid in the cycle after rst rises.
REQ-031 First cycle with rst=0 issues RESET_PC.

Verification
REQ-032 Reset release, id_ready=1, memory word at addr 4k = 32'hA000_0000+k: id_valid first rises 2 cycles after release with id_pc=0/id_instr=A000_0000, then pcs 4,8,12 every cycle.
REQ-033 Stall: id_ready=0 for 5 cycles mid-stream at id_pc=8: id_* hold pc 8, imem_pc never issues more than 2 ahead, and on release pcs 8,12,16 are delivered with no loss or duplicate.
REQ-034 Redirect to 10'h104 (redirect_pc 10'h105 given) while FIFO full: id_valid=0 that cycle and the next, then id_pc=10'h104, 10'h108 follow, with no pre-redirect pc delivered afterwards.
REQ-035 Wrap: redirect to 10'h3F8 with id_ready=1: delivered pcs 3F8, 3FC, 000, 004.
REQ-036 Reset asserted 1 cycle mid-stream at pc 20: id_valid=0 next cycle, and the stream restarts at RESET_PC 2 cycles after release.
REQ-037 Random id_ready/redirect for 10k cycles vs reference model: delivered pc sequence matches, and the FIFO count never exceeds 2.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch front end. Issues word-aligned addresses to
//               a registered-read instruction memory, catches the returning
//               words in a 2-entry {pc, instr} FIFO and presents the head to
//               decode with a valid/ready handshake. A redirect flushes all
//               buffered and in-flight work and restarts fetch at the target.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [9:0] RESET_PC = 10'h000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [9:0]  imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [9:0]  redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [9:0]  id_pc,
  output logic [31:0] id_instr
);

  // Fetch pointer and the single outstanding memory request.
  logic [9:0]  r_fetch_pc;
  logic        r_inflight;
  logic [9:0]  r_inflight_pc;

  // Two-entry FIFO, entry 0 is always the head.
  logic [9:0]  r_fifo_pc    [2];
  logic [31:0] r_fifo_instr [2];
  logic [1:0]  r_count;

  logic        w_pop;
  logic        w_push;
  logic        w_issue;
  logic [1:0]  w_count_after_pop;
  logic [1:0]  w_occupancy;
  logic [9:0]  w_redirect_aligned;

  assign w_redirect_aligned = {redirect_pc[9:2], 2'b00};
  assign imem_pc            = redirect_valid ? w_redirect_aligned : r_fetch_pc;

  // Decode only sees the FIFO head; a redirect cycle never transfers, and
  // reset masks whatever the buffers still hold on the first reset cycle.
  assign id_valid = (r_count != 2'd0) && !redirect_valid && !rst;
  assign id_pc    = rst ? 10'd0 : r_fifo_pc[0];
  assign id_instr = rst ? 32'd0 : r_fifo_instr[0];

  assign w_pop             = id_valid && id_ready;
  assign w_count_after_pop = r_count - {1'b0, w_pop};
  // Buffered plus outstanding work; at most 3, so 2 bits suffice.
  assign w_occupancy       = w_count_after_pop + {1'b0, r_inflight};

  // A new request is only sent when its response is guaranteed a FIFO slot.
  // A redirect always issues because the flush frees every slot.
  assign w_issue = !rst && (redirect_valid || (w_occupancy <= 2'd1));

  // A response arriving during a redirect belongs to the abandoned stream.
  assign w_push  = r_inflight && !redirect_valid;

  // Fetch pointer and outstanding-request tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= 10'd0;
    end else if (w_issue) begin
      r_inflight    <= 1'b1;
      r_inflight_pc <= imem_pc;
      r_fetch_pc    <= imem_pc + 10'd4;
    end else begin
      r_inflight    <= 1'b0;
    end
  end

  // FIFO storage: shift on pop, then write the returning word behind the
  // surviving entries so order is preserved on simultaneous push and pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_fifo_pc[i]    <= 10'd0;
        r_fifo_instr[i] <= 32'd0;
      end
      r_count <= 2'd0;
    end else if (redirect_valid) begin
      r_count <= 2'd0;
    end else begin
      if (w_pop) begin
        r_fifo_pc[0]    <= r_fifo_pc[1];
        r_fifo_instr[0] <= r_fifo_instr[1];
      end
      if (w_push) begin
        r_fifo_pc[w_count_after_pop[0]]    <= r_inflight_pc;
        r_fifo_instr[w_count_after_pop[0]] <= imem_instr;
      end
      r_count <= w_count_after_pop + {1'b0, w_push};
    end
  end

endmodule
`default_nettype wire
